// File: rtl/basemul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, 17 digits for a
// 33-bit signed multiplier, 64-bit product held until the next completion.
module basemul (
   input  logic        mul_clk,
   input  logic        resetn,
   input  logic [32:0] src1,
   input  logic [32:0] src2,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   output logic [63:0] result,
   output logic [1:0]  dbg_state
);

   // Handshake: operands are taken on a rising edge where in_valid && in_ready;
   // out_valid is high for exactly the DONE cycle, and result holds until the next DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [34:0] mplr_q, mplr_d;
   logic [65:0] mcand_q, mcand_d;
   logic [65:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] result_q, result_d;
   logic [65:0] pp;
   logic [65:0] sum;
   logic        accept;
   logic        last_digit;

   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt_q == 5'd16);

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (last_digit) state_d = DONE;
         DONE:    state_d = in_valid ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q != BUSY);
      out_valid = (state_q == DONE);
      dbg_state = state_q;
   end

   // mplr_q[2:0] is the current digit window {2k+1, 2k, 2k-1}; mcand_q is src2 << 2k.
   always_comb begin
      case (mplr_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = 66'd0;
      endcase
   end

   assign sum = acc_q + pp;

   always_comb begin
      mplr_d   = mplr_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (accept) begin
         mplr_d  = {src1[32], src1, 1'b0};
         mcand_d = {{33{src2[32]}}, src2};
         acc_d   = 66'd0;
         cnt_d   = 5'd0;
      end else if (state_q == BUSY) begin
         acc_d   = sum;
         mplr_d  = {{2{mplr_q[34]}}, mplr_q[34:2]};
         mcand_d = mcand_q << 2;
         cnt_d   = cnt_q + 5'd1;
         if (last_digit) result_d = sum[63:0];
      end
   end

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         mplr_q   <= 35'd0;
         mcand_q  <= 66'd0;
         acc_q    <= 66'd0;
         cnt_q    <= 5'd0;
         result_q <= 64'd0;
      end else begin
         mplr_q   <= mplr_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_basemul.sv
// Self-checking bench for basemul: directed literal products, back-to-back
// random throughput, mid-operation reset, all checked against a product model.
module tb_basemul;

   logic        mul_clk = 1'b0;
   logic        resetn = 1'b0;
   logic [32:0] src1 = 33'd0;
   logic [32:0] src2 = 33'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] result;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];
   int          done_edge = 0;
   int          edge_n = 0;
   logic        exp_ready = 1'b1;
   logic        exp_ov = 1'b0;
   logic [63:0] exp_res = 64'd0;
   bit          chk_en = 1'b0;

   basemul dut (
      .mul_clk   (mul_clk),
      .resetn    (resetn),
      .src1      (src1),
      .src2      (src2),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .result    (result),
      .dbg_state (dbg_state)
   );

   always #5 mul_clk = ~mul_clk;

   function automatic logic [63:0] prod(input logic [32:0] a, input logic [32:0] b);
      logic signed [65:0] p;
      p = $signed({{33{a[32]}}, a}) * $signed({{33{b[32]}}, b});
      return p[63:0];
   endfunction

   function automatic logic [32:0] rand_op();
      logic [31:0] v;
      logic        s;
      v = $urandom();
      s = 1'($urandom_range(1, 0));
      return {s ? v[31] : 1'b0, v};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Model: each accepted pair yields its product 17 edges later for one cycle.
   initial forever begin
      @(posedge mul_clk);
      edge_n++;
      if (!resetn) begin
         exp_q.delete();
         exp_ready = 1'b1;
         exp_ov    = 1'b0;
         exp_res   = 64'd0;
      end else begin
         exp_ov = 1'b0;
         if (exp_q.size() > 0 && edge_n == done_edge) begin
            exp_res   = exp_q.pop_front();
            exp_ov    = 1'b1;
            exp_ready = 1'b1;
         end else if (exp_ready && in_valid) begin
            exp_q.push_back(prod(src1, src2));
            done_edge = edge_n + 17;
            exp_ready = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge mul_clk);
      if (chk_en) begin
         check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
         check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
         check("result", result, exp_res);
      end
   end

   // Presents operands now, accepts on the next edge, scrambles inputs while busy.
   task automatic do_op(input logic [32:0] a, input logic [32:0] b,
                        input logic [63:0] lit, input string nm);
      int n;
      src1 = a;
      src2 = b;
      in_valid = 1'b1;
      @(posedge mul_clk);
      #1;
      in_valid = 1'b0;
      src1 = rand_op();
      src2 = rand_op();
      n = 0;
      while (n < 40) begin
         @(posedge mul_clk);
         n++;
         #1;
         src1 = rand_op();
         if (out_valid) break;
      end
      if (n >= 40) $display("FAIL %s_timeout: no out_valid, dbg_state %0d", nm, dbg_state);
      check({nm, "_latency"}, 64'(n), 64'd17);
      check({nm, "_result"}, result, lit);
   endtask

   initial begin
      int n_pulses;
      int n_prod;
      repeat (3) @(posedge mul_clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_result", result, 64'd0);
      check("model_uns", prod({1'b0, 32'hFFFFFFFF}, {1'b0, 32'hFFFFFFFF}), 64'hFFFFFFFE00000001);
      check("model_mix", prod({1'b0, 32'h7FFFFFFF}, {1'b1, 32'h80000000}), 64'hC000000080000000);
      resetn = 1'b1;
      chk_en = 1'b1;
      // First edge with resetn=1 accepts.
      do_op({1'b0, 32'hFFFFFFFF}, {1'b0, 32'hFFFFFFFF}, 64'hFFFFFFFE00000001, "uns_max");
      // Back-to-back from DONE.
      do_op({1'b1, 32'hFFFFFFFF}, {1'b1, 32'hFFFFFFFF}, 64'h0000000000000001, "neg1_sq");
      @(posedge mul_clk);
      #1;
      do_op({1'b1, 32'h80000000}, {1'b1, 32'h80000000}, 64'h4000000000000000, "minint_sq");
      @(posedge mul_clk);
      #1;
      do_op({1'b0, 32'h7FFFFFFF}, {1'b1, 32'h80000000}, 64'hC000000080000000, "mixed");
      do_op(33'd0, {1'b1, 32'h92345678}, 64'd0, "zero_x");
      do_op({1'b1, 32'hFFFFFFFD}, 33'd0, 64'd0, "x_zero");
      do_op({1'b0, 32'd3}, {1'b0, 32'd5}, 64'd15, "small");
      do_op({1'b1, 32'hFFFFFFFD}, {1'b0, 32'd7}, 64'hFFFFFFFFFFFFFFEB, "neg_small");
      do_op({1'b0, 32'h80000000}, {1'b0, 32'hFFFFFFFF}, 64'h7FFFFFFF80000000, "uns_hi");
      @(posedge mul_clk);
      #1;

      // Reset on edge 8 of BUSY aborts the operation.
      src1 = {1'b0, 32'h12345678};
      src2 = {1'b0, 32'h9ABCDEF0};
      in_valid = 1'b1;
      @(posedge mul_clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge mul_clk);
      #1;
      resetn = 1'b0;
      @(posedge mul_clk);
      #1;
      resetn = 1'b1;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_result", result, 64'd0);
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (20) @(posedge mul_clk);
      #1;
      check("abort_no_pulse", {63'd0, out_valid}, 64'd0);
      do_op({1'b0, 32'h12345678}, {1'b0, 32'h9ABCDEF0}, 64'h0B00EA4E242D2080, "post_abort");
      @(posedge mul_clk);
      #1;

      // Continuous in_valid: one product per 18-cycle slot.
      n_prod = 3000;
      n_pulses = 0;
      src1 = rand_op();
      src2 = rand_op();
      in_valid = 1'b1;
      for (int i = 0; i < 18 * n_prod; i++) begin
         @(posedge mul_clk);
         #1;
         src1 = rand_op();
         src2 = rand_op();
         if (out_valid) n_pulses++;
      end
      in_valid = 1'b0;
      check("stream_pulses", 64'(n_pulses), 64'(n_prod));

      repeat (5) @(posedge mul_clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, dbg_state %0d", dbg_state);
      $fatal(1, "watchdog expired");
   end

endmodule
